// File: rtl/div_sequencer.sv
// Radix-2 restoring divide sequencer for DIV/DIVU in EX.
// Define DIV_EARLY_OUT_EN to finish at once when |opa| < |opb|.
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             flush,
   output logic             div_stall,
   output logic             div_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic             sign_q;
   logic             sign_r;

   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             take;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] dvd_nx;
   logic             early;

   always_comb begin
      mag_a = (div_signed && opa[WIDTH-1]) ? -opa : opa;
      mag_b = (div_signed && opb[WIDTH-1]) ? -opb : opb;
`ifdef DIV_EARLY_OUT_EN
      early = (mag_b != '0) && (mag_a < mag_b);
`else
      early = 1'b0;
`endif
   end

   // rem < dvs always holds, so the difference fits WIDTH bits
   always_comb begin
      shifted = {rem, dvd[WIDTH-1]};
      trial   = shifted - {1'b0, dvs};
      take    = (shifted >= {1'b0, dvs});
      rem_nx  = take ? trial[WIDTH-1:0]
                     : shifted[WIDTH-1:0];
      dvd_nx  = {dvd[WIDTH-2:0], take};
   end

   assign div_stall = resetn && !flush &&
                      ((state == IDLE && div_start) ||
                       state == BUSY);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         count     <= '0;
         rem       <= '0;
         dvd       <= '0;
         dvs       <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         div_ready <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         div_ready <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (div_start) begin
                     rem    <= '0;
                     dvd    <= mag_a;
                     dvs    <= mag_b;
                     count  <= '0;
                     sign_q <= div_signed &
                               (opa[WIDTH-1] ^ opb[WIDTH-1]);
                     sign_r <= div_signed & opa[WIDTH-1];
                     if (mag_b == '0) begin
                        state     <= DONE;
                        div_ready <= 1'b1;
                        quotient  <= '1;
                        remainder <= opa;
                     end else if (early) begin
                        state     <= DONE;
                        div_ready <= 1'b1;
                        quotient  <= '0;
                        remainder <= opa;
                     end else begin
                        state <= BUSY;
                     end
                  end
               end
               BUSY: begin
                  rem   <= rem_nx;
                  dvd   <= dvd_nx;
                  count <= count + 1'b1;
                  if (count == CW'(WIDTH-1)) begin
                     state     <= DONE;
                     div_ready <= 1'b1;
                     quotient  <= sign_q ? -dvd_nx : dvd_nx;
                     remainder <= sign_r ? -rem_nx : rem_nx;
                  end
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
